// File: rtl/pong_match_ctrl.sv
// rtl/pong_match_ctrl.sv - Pong match sequencer: game FSM, tick divider, scores, serve direction.
module pong_match_ctrl #(
    parameter int TICK_DIV    = 65536,
    parameter int SERVE_TICKS = 60,
    parameter int POINT_TICKS = 90,
    parameter int WIN_SCORE   = 9
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start_btn,
    input  logic       i_miss_left,
    input  logic       i_miss_right,
    output logic       o_ball_step,
    output logic       o_ball_recenter,
    output logic       o_serve_right,
    output logic [3:0] o_score_left,
    output logic [3:0] o_score_right,
    output logic [2:0] o_state,
    output logic       o_playing,
    output logic       o_game_over
);

    localparam int DIV_W   = $clog2(TICK_DIV);
    localparam int CNT_MAX = (SERVE_TICKS > POINT_TICKS) ? SERVE_TICKS : POINT_TICKS;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] SERVE_LOAD = CNT_W'(SERVE_TICKS - 1);
    localparam logic [CNT_W-1:0] POINT_LOAD = CNT_W'(POINT_TICKS - 1);
    localparam logic [3:0]       WIN        = 4'(WIN_SCORE);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_POINT = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    logic             r_sync1, r_sync2, r_sync3;
    logic [DIV_W-1:0] r_div;
    logic             r_tick;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_score_l, r_score_r;
    logic             r_serve_right;
    logic             r_ball_step, r_recenter;
    logic             r_playing, r_game_over;

    logic             w_start_edge;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [3:0]       w_score_l_nxt, w_score_r_nxt;
    logic             w_serve_nxt, w_step_nxt, w_recenter_nxt;

    assign w_start_edge = r_sync2 & ~r_sync3;

    // Button synchronizer, free-running tick divider and registered tick
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
            r_div   <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_sync1 <= i_start_btn;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            r_div   <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
            r_tick  <= (r_div == DIV_LAST);
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_score_l_nxt  = r_score_l;
        w_score_r_nxt  = r_score_r;
        w_serve_nxt    = r_serve_right;
        w_step_nxt     = 1'b0;
        w_recenter_nxt = 1'b0;
        case (r_state)
            S_IDLE, S_OVER: begin
                if (w_start_edge) begin
                    w_state_nxt    = S_SERVE;
                    w_score_l_nxt  = 4'd0;
                    w_score_r_nxt  = 4'd0;
                    w_serve_nxt    = 1'b1;
                    w_recenter_nxt = 1'b1;
                    w_cnt_nxt      = SERVE_LOAD;
                end
            end
            S_SERVE: begin
                if (r_tick) begin
                    if (r_cnt == '0) w_state_nxt = S_PLAY;
                    else             w_cnt_nxt   = r_cnt - 1'b1;
                end
            end
            S_PLAY: begin
                // Left miss has priority; any miss swallows a coincident step
                if (i_miss_left) begin
                    w_score_r_nxt = r_score_r + 4'd1;
                    w_serve_nxt   = 1'b0;
                    w_state_nxt   = ((r_score_r + 4'd1) == WIN) ? S_OVER : S_POINT;
                    w_cnt_nxt     = POINT_LOAD;
                end else if (i_miss_right) begin
                    w_score_l_nxt = r_score_l + 4'd1;
                    w_serve_nxt   = 1'b1;
                    w_state_nxt   = ((r_score_l + 4'd1) == WIN) ? S_OVER : S_POINT;
                    w_cnt_nxt     = POINT_LOAD;
                end else if (r_tick) begin
                    w_step_nxt = 1'b1;
                end
            end
            S_POINT: begin
                if (r_tick) begin
                    if (r_cnt == '0) begin
                        w_state_nxt    = S_SERVE;
                        w_recenter_nxt = 1'b1;
                        w_cnt_nxt      = SERVE_LOAD;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_score_l     <= 4'd0;
            r_score_r     <= 4'd0;
            r_serve_right <= 1'b1;
            r_ball_step   <= 1'b0;
            r_recenter    <= 1'b0;
            r_playing     <= 1'b0;
            r_game_over   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_score_l     <= w_score_l_nxt;
            r_score_r     <= w_score_r_nxt;
            r_serve_right <= w_serve_nxt;
            r_ball_step   <= w_step_nxt;
            r_recenter    <= w_recenter_nxt;
            r_playing     <= (w_state_nxt == S_PLAY);
            r_game_over   <= (w_state_nxt == S_OVER);
        end
    end

    assign o_state         = r_state;
    assign o_score_left    = r_score_l;
    assign o_score_right   = r_score_r;
    assign o_serve_right   = r_serve_right;
    assign o_ball_step     = r_ball_step;
    assign o_ball_recenter = r_recenter;
    assign o_playing       = r_playing;
    assign o_game_over     = r_game_over;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// tb/tb_pong_match_ctrl.sv - randomized scoreboard bench for pong_match_ctrl.
module tb_pong_match_ctrl;
    localparam int TD = 4;
    localparam int ST = 2;
    localparam int PT = 3;
    localparam int WS = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_btn = 1'b0;
    logic       miss_left = 1'b0;
    logic       miss_right = 1'b0;
    logic       ball_step, ball_recenter, serve_right, playing, game_over;
    logic [3:0] score_left, score_right;
    logic [2:0] state;

    always #5 clk = ~clk;

    pong_match_ctrl #(
        .TICK_DIV(TD), .SERVE_TICKS(ST), .POINT_TICKS(PT), .WIN_SCORE(WS)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start_btn(start_btn),
        .i_miss_left(miss_left), .i_miss_right(miss_right),
        .o_ball_step(ball_step), .o_ball_recenter(ball_recenter),
        .o_serve_right(serve_right), .o_score_left(score_left),
        .o_score_right(score_right), .o_state(state),
        .o_playing(playing), .o_game_over(game_over)
    );

    typedef struct packed {
        logic [2:0] st;
        logic [3:0] sl;
        logic [3:0] sr;
        logic       srv;
        logic       step;
        logic       rec;
        logic       ply;
        logic       ovr;
    } snap_t;

    typedef struct {
        int    e;
        snap_t s;
    } exp_t;

    exp_t  sb_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    edge_cnt;

    // Reference model: match-level view, phases measured in remaining ticks
    int    m_st, m_sl, m_sr, m_srv, m_left;
    logic  p1, p2, p3;
    logic  lvl = 1'b0;
    int    hold = 0;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;

    function automatic snap_t dut_snap();
        snap_t s;
        s.st = state; s.sl = score_left; s.sr = score_right; s.srv = serve_right;
        s.step = ball_step; s.rec = ball_recenter; s.ply = playing; s.ovr = game_over;
        return s;
    endfunction

    function automatic string fmt(input snap_t s);
        return $sformatf("st=%0d score=%0d/%0d srv=%b step=%b rec=%b ply=%b ovr=%b",
                         s.st, s.sl, s.sr, s.srv, s.step, s.rec, s.ply, s.ovr);
    endfunction

    task automatic model_reset();
        m_st = 0; m_sl = 0; m_sr = 0; m_srv = 1; m_left = 0;
        p1 = 1'b0; p2 = 1'b0; p3 = 1'b0;
    endtask

    task automatic model_edge(input int e, input logic btn, input logic ml,
                              input logic mr, output snap_t s);
        logic tick, press, step, rec;
        tick  = (e > 1) && ((e - 1) % TD == 0);
        press = p2 & ~p3;
        p3 = p2; p2 = p1; p1 = btn;
        step = 1'b0;
        rec  = 1'b0;
        case (m_st)
            0, 4: if (press) begin
                m_sl = 0; m_sr = 0; m_srv = 1; rec = 1'b1; m_st = 1; m_left = ST;
            end
            1: if (tick) begin
                m_left--;
                if (m_left == 0) m_st = 2;
            end
            2: if (ml || mr) begin
                if (ml) begin m_sr++; m_srv = 0; end
                else    begin m_sl++; m_srv = 1; end
                m_st   = (m_sl == WS || m_sr == WS) ? 4 : 3;
                m_left = PT;
            end else if (tick) begin
                step = 1'b1;
            end
            3: if (tick) begin
                m_left--;
                if (m_left == 0) begin m_st = 1; rec = 1'b1; m_left = ST; end
            end
            default: ;
        endcase
        s.st = 3'(m_st); s.sl = 4'(m_sl); s.sr = 4'(m_sr); s.srv = (m_srv != 0);
        s.step = step; s.rec = rec; s.ply = (m_st == 2); s.ovr = (m_st == 4);
    endtask

    task automatic drive_cycle(input int c);
        snap_t s;
        exp_t  x;
        logic  ml, mr;
        if (c < 50) begin
            lvl = 1'b0;
        end else if (hold == 0) begin
            lvl  = 1'($urandom_range(0, 1));
            hold = $urandom_range(1, 15);
        end else begin
            hold--;
        end
        if ($urandom_range(0, 39) == 0) begin
            ml = 1'b1; mr = 1'b1;
        end else begin
            ml = ($urandom_range(0, 19) == 0);
            mr = ($urandom_range(0, 19) == 0);
        end
        start_btn = lvl; miss_left = ml; miss_right = mr;
        model_edge(edge_cnt + 1, lvl, ml, mr, s);
        x.e = edge_cnt + 1;
        x.s = s;
        sb_q.push_back(x);
    endtask

    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            while (rst_n && sb_q.size() > 0 && sb_q[0].e <= edge_cnt) begin
                x = sb_q.pop_front();
                n_cmp++;
                if (x.e != edge_cnt || dut_snap() != x.s) begin
                    n_bad++;
                    $display("FAIL edge%0d outputs: actual %s, required %s",
                             x.e, fmt(dut_snap()), fmt(x.s));
                end
            end
        end
    end

    initial begin
        snap_t rs;
        bit    found;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 5000; c++) begin
            if (c == 2500) begin
                found = 1'b0;
                for (int w = 0; w < 2000 && !found; w++) begin
                    drive_cycle(c);
                    @(posedge clk); #1;
                    if (m_st == 2) found = 1'b1;
                end
                n_cmp++;
                if (!found) begin
                    n_bad++;
                    $display("FAIL play_wait: actual no PLAY state, required PLAY within 2000 cycles");
                end else begin
                    #5 rst_n = 1'b0;
                    #1;
                    rs.st = 3'd0; rs.sl = 4'd0; rs.sr = 4'd0; rs.srv = 1'b1;
                    rs.step = 1'b0; rs.rec = 1'b0; rs.ply = 1'b0; rs.ovr = 1'b0;
                    n_cmp++;
                    if (dut_snap() != rs) begin
                        n_bad++;
                        $display("FAIL async_reset: actual %s, required %s", fmt(dut_snap()), fmt(rs));
                    end
                    sb_q.delete();
                    model_reset();
                    miss_left = 1'b0; miss_right = 1'b0;
                    @(posedge clk);
                    #1 rst_n = 1'b1;
                end
            end
            drive_cycle(c);
            @(posedge clk); #1;
        end
        miss_left = 1'b0; miss_right = 1'b0; start_btn = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: actual %0d pending, required 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pong_match_ctrl.md
# pong_match_ctrl

Match sequencer for the Pong game. It owns the game-level state machine (idle, serve, play, point pause, game over) and generates the ball-step strobe that paces the ball engine. It keeps both players' scores and decides the serve direction. It sits between the player start button, the ball engine's miss detection, and the score/ball datapath.

## Interface
Parameters:
- TICK_DIV, 65536: clocks per game tick; must be ≥ 2.
- SERVE_TICKS, 60: ticks the ball is held centred before play starts; must be ≥ 1.
- POINT_TICKS, 90: ticks of pause after a point is scored; must be ≥ 1.
- WIN_SCORE, 9: score that ends the match; range 1–15.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- start_btn  in  1  raw start button, level, asynchronous to clk.
- miss_left  in  1  1-cycle pulse: ball passed the left edge, so the right player scores.
- miss_right  in  1  1-cycle pulse: ball passed the right edge, so the left player scores.
- ball_step  out  1  1-cycle pulse: ball engine advances one step.
- ball_recenter  out  1  1-cycle pulse: ball engine reloads the centre position.
- serve_right  out  1  serve direction for the next serve (1 = toward the right).
- score_left  out  4  left player score.
- score_right  out  4  right player score.
- state  out  3  encoding: IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4.
- playing  out  1  high while state == PLAY.
- game_over  out  1  high while state == OVER.

## Operation
Start button handling:
- start_btn passes through a two-flop synchronizer.
- start_edge = sync2 & ~sync3, giving a single pulse per press.
- A held button produces no further edges.

Tick generator:
- The divider counts 0..TICK_DIV-1 and wraps to 0. It runs in every state.
- The registered tick is high for the one clock after the divider reaches TICK_DIV-1.

Phase counter cnt:
- Loaded on entry to SERVE/POINT with the count - 1.
- On each tick: if cnt == 0, the exit transition fires; otherwise cnt decrements.
- Each timed state therefore lasts exactly its tick count.

State transitions:
- **IDLE**: on start_edge, go to SERVE.
  - Clear both scores.
  - Set serve_right = 1.
  - Pulse ball_recenter.
  - Load cnt = SERVE_TICKS-1.
- **SERVE**: on the tick with cnt == 0, go to PLAY.
- **PLAY**: ball_step pulses on the clock after each tick.
  - miss_left: score_right += 1 and serve_right = 0.
  - miss_right: score_left += 1 and serve_right = 1.
  - If the incremented score equals WIN_SCORE, go to OVER; otherwise go to POINT with cnt = POINT_TICKS-1.
  - A miss in the same cycle as a tick suppresses that ball_step.
- **POINT**: on the tick with cnt == 0, go to SERVE, pulse ball_recenter, and load cnt = SERVE_TICKS-1.
- **OVER**: scores are held. On start_edge, behave exactly as IDLE + start_edge (new match straight into SERVE).

Boundary cases:
- miss_left and miss_right in the same cycle: miss_left wins; miss_right is dropped.
- Misses outside PLAY are ignored.
- start_edge in SERVE, PLAY or POINT is ignored.
- Scores never exceed WIN_SCORE, so no wrap handling is needed.
- Reset asserted mid-match returns everything to reset values immediately, regardless of the clock.

## Timing
All outputs are registered and change only on the rising edge of clk, except under asynchronous reset.

Reset values:
- state = IDLE.
- score_left = score_right = 0.
- serve_right = 1.
- ball_step = 0, ball_recenter = 0.
- playing = 0, game_over = 0.
- Internal: divider = 0, cnt = 0, synchronizers = 0.

Latencies:
- Start: start_btn high before edge k appears as start_edge at edge k+2. state/ball_recenter update at edge k+2.
- ball_step: asserted one clock after a tick, for exactly one clock.
- Miss: a miss pulse sampled at edge n updates score, state and serve_right at edge n.
- Tick: the first tick after reset release occurs TICK_DIV clocks after reset release; ticks then repeat every TICK_DIV clocks.
- SERVE duration: SERVE_TICKS ticks. POINT duration: POINT_TICKS ticks.
- ball_recenter is high for exactly one clock per entry into SERVE.

## Test plan
Parameters for all scenarios: TICK_DIV=4, SERVE_TICKS=2, POINT_TICKS=3, WIN_SCORE=3.

1. **Reset and idle.** Release reset, hold start_btn=0 for 50 clocks → state=0, scores 0/0, serve_right=1, no ball_step pulse, no ball_recenter pulse.
2. **Start and serve.** Pulse start_btn for 10 clocks → exactly one ball_recenter pulse; state=1 for 2 ticks, then 2; then one ball_step per 4 clocks, each one clock after a tick.
3. **Point scored.** In PLAY, pulse miss_left → score_right=1, serve_right=0, state=3; after 3 ticks state=1 with one ball_recenter pulse; after 2 more ticks state=2.
4. **Simultaneous misses and tick collision.** Drive miss_left and miss_right together, on a cycle coinciding with a tick → only score_right increments; no ball_step follows that tick.
5. **Win and restart.** Three miss_right events across rallies → score_left=3, state=4, game_over=1; extra misses and ball_step stay inert. A start press → scores 0/0, state=1, serve_right=1.
6. **Reset mid-match.** Assert rst_n low asynchronously mid-PLAY with score 2/1 → outputs take reset values immediately, without a clock edge. Start presses during SERVE/PLAY/POINT are ignored.
